// File: rtl/i2c_reg_ctrl.sv
// I2C-driven 16x8 configuration register bank with a local host write/read port.
// Register 15 is a read-only count of completed I2C write transactions.
module i2c_reg_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   i2c_byte,
    input  logic         i2c_byte_vld,
    input  logic         i2c_idle,
    input  logic         host_we,
    input  logic [3:0]   host_addr,
    input  logic [7:0]   host_wdata,
    output logic         host_ack,
    input  logic [3:0]   host_raddr,
    output logic [7:0]   host_rdata,
    output logic [119:0] cfg_regs,
    output logic         cfg_update,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DEV  = 3'd1,
        S_PTR  = 3'd2,
        S_DATA = 3'd3,
        S_READ = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_ptr;
    logic       r_wrote;
    logic       r_cfg_update;
    logic       r_host_armed;
    logic [7:0] r_rdata;
    logic [7:0] r_bank [0:15];

    logic       w_i2c_wr;
    logic       w_host_wr;
    logic       w_txn_done;

    // A data byte claims the bank port only when it actually lands in a writable register.
    assign w_i2c_wr   = (r_state == S_DATA) && i2c_byte_vld && !i2c_idle && (r_ptr != 4'd15);
    assign w_host_wr  = host_we && r_host_armed && !w_i2c_wr && !rst;
    assign w_txn_done = (r_state == S_DATA) && i2c_idle && r_wrote;

    assign host_ack   = w_host_wr;
    assign host_rdata = r_rdata;
    assign cfg_update = r_cfg_update;
    assign busy       = (r_state != S_IDLE);

    genvar g;
    generate
        for (g = 0; g < 15; g = g + 1) begin : g_cfg
            assign cfg_regs[8*g +: 8] = r_bank[g];
        end
    endgenerate

    // Transaction FSM: STOP (i2c_idle) wins over any byte arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= 4'd0;
            r_wrote      <= 1'b0;
            r_cfg_update <= 1'b0;
        end else begin
            r_cfg_update <= 1'b0;
            if ((r_state != S_IDLE) && i2c_idle) begin
                r_state      <= S_IDLE;
                r_wrote      <= 1'b0;
                r_cfg_update <= w_txn_done;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!i2c_idle) begin
                            r_state <= S_DEV;
                            r_wrote <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DEV: begin
                        if (i2c_byte_vld) begin
                            r_state <= i2c_byte[0] ? S_READ : S_PTR;
                        end else begin
                            r_state <= S_DEV;
                        end
                    end
                    S_PTR: begin
                        if (i2c_byte_vld) begin
                            r_ptr   <= i2c_byte[3:0];
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_PTR;
                        end
                    end
                    S_DATA: begin
                        if (i2c_byte_vld) begin
                            r_ptr   <= r_ptr + 4'd1;
                            r_wrote <= 1'b1;
                        end else begin
                            r_ptr   <= r_ptr;
                        end
                    end
                    S_READ: begin
                        r_state <= S_READ;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Register bank: I2C data first, host write otherwise; reg 15 only moves as the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_bank[i] <= 8'h00;
            end
        end else begin
            if (w_i2c_wr) begin
                r_bank[r_ptr] <= i2c_byte;
            end else if (w_host_wr && (host_addr != 4'd15)) begin
                r_bank[host_addr] <= host_wdata;
            end
            if (w_txn_done) begin
                r_bank[15] <= r_bank[15] + 8'd1;
            end
        end
    end

    // Host request re-arms only after host_we has been seen low once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_host_armed <= 1'b1;
        end else if (!host_we) begin
            r_host_armed <= 1'b1;
        end else if (w_host_wr) begin
            r_host_armed <= 1'b0;
        end else begin
            r_host_armed <= r_host_armed;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 8'h00;
        end else begin
            r_rdata <= r_bank[host_raddr];
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level model of the register bank.
module tb_i2c_reg_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   i2c_byte;
    logic         i2c_byte_vld;
    logic         i2c_idle;
    logic         host_we;
    logic [3:0]   host_addr;
    logic [7:0]   host_wdata;
    logic         host_ack;
    logic [3:0]   host_raddr;
    logic [7:0]   host_rdata;
    logic [119:0] cfg_regs;
    logic         cfg_update;
    logic         busy;

    int           checks  = 0;
    int           errors  = 0;
    int           upd_cnt = 0;
    int           exp_upd;
    logic [7:0]   mbank [16];
    logic [7:0]   txq [$];

    always #5 clk = ~clk;

    i2c_reg_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i2c_byte     (i2c_byte),
        .i2c_byte_vld (i2c_byte_vld),
        .i2c_idle     (i2c_idle),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_raddr   (host_raddr),
        .host_rdata   (host_rdata),
        .cfg_regs     (cfg_regs),
        .cfg_update   (cfg_update),
        .busy         (busy)
    );

    // Count every cycle cfg_update is seen high.
    always @(negedge clk) begin
        if (cfg_update === 1'b1) upd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [119:0] exp_cfg();
        logic [119:0] v;
        for (int n = 0; n < 15; n++) v[8*n +: 8] = mbank[n];
        return v;
    endfunction

    // Transaction-level effect of the bytes in txq: dev, pointer, then data.
    task automatic model_txn();
        logic [3:0] p;
        int a;
        exp_upd = 0;
        if (txq.size() >= 3 && txq[0][0] == 1'b0) begin
            p = txq[1][3:0];
            for (int k = 2; k < txq.size(); k++) begin
                a = (int'(p) + k - 2) % 16;
                if (a != 15) mbank[a] = txq[k];
            end
            mbank[15] = mbank[15] + 8'd1;
            exp_upd = 1;
        end
    endtask

    task automatic check_bank(input string tag);
        logic [3:0] ra;
        chk({tag, "_cfg"}, cfg_regs, exp_cfg());
        host_raddr = 4'd15;
        tick();
        chk({tag, "_r15"}, host_rdata, mbank[15]);
        ra = 4'($urandom_range(0, 15));
        host_raddr = ra;
        tick();
        chk({tag, "_rd"}, host_rdata, mbank[ra]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i2c_byte     = b;
        i2c_byte_vld = 1'b1;
        tick();
        i2c_byte_vld = 1'b0;
    endtask

    task automatic run_txn(input string tag);
        int base;
        base = upd_cnt;
        i2c_idle = 1'b0;
        tick();
        chk({tag, "_busy"}, busy, 1'b1);
        tick();
        foreach (txq[i]) begin
            send_byte(txq[i]);
            tick();
        end
        i2c_idle = 1'b1;
        tick();
        tick();
        chk({tag, "_idle"}, busy, 1'b0);
        model_txn();
        chk({tag, "_upd"}, upd_cnt - base, exp_upd);
        check_bank(tag);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d, input string tag);
        int n;
        n = 0;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        #1;
        while (host_ack !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        chk({tag, "_ack"}, host_ack, 1'b1);
        chk({tag, "_lat"}, n, 0);
        if (host_ack === 1'b1 && a != 4'd15) mbank[a] = d;
        tick();
        chk({tag, "_noreack"}, host_ack, 1'b0);
        host_we = 1'b0;
        tick();
        check_bank(tag);
    endtask

    initial begin
        int base;
        int kind;
        int len;
        rst = 1'b1; i2c_byte = 8'h00; i2c_byte_vld = 1'b0; i2c_idle = 1'b1;
        host_we = 1'b0; host_addr = 4'd0; host_wdata = 8'h00; host_raddr = 4'd0;
        for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
        tick(); tick(); tick();
        chk("rst_cfg", cfg_regs, 120'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_upd", cfg_update, 1'b0);
        chk("rst_rdata", host_rdata, 8'h00);
        host_we = 1'b1;
        #1;
        chk("rst_ack", host_ack, 1'b0);
        host_we = 1'b0;
        rst = 1'b0;
        tick();

        txq = '{8'h50, 8'h03, 8'hAA, 8'hBB};
        run_txn("write");
        chk("write_reg3", cfg_regs[31:24], 8'hAA);
        chk("write_reg4", cfg_regs[39:32], 8'hBB);

        txq = '{8'h50, 8'h0E, 8'h11, 8'h22, 8'h33};
        run_txn("wrap");
        chk("wrap_reg14", cfg_regs[119:112], 8'h11);
        chk("wrap_reg0", cfg_regs[7:0], 8'h33);

        txq = '{8'h51, 8'h07, 8'h99};
        run_txn("read");

        txq = '{8'h50, 8'h07};
        run_txn("devptr");

        host_write(4'd15, 8'hEE, "hw15");
        host_write(4'd9, 8'h3C, "hw9");

        // Arbitration: host request collides with an I2C data byte to the same register.
        base = upd_cnt;
        i2c_idle = 1'b0;
        tick(); tick();
        send_byte(8'h50); tick();
        send_byte(8'h05); tick();
        i2c_byte = 8'h77; i2c_byte_vld = 1'b1;
        host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'h5A;
        #1;
        chk("arb_blocked", host_ack, 1'b0);
        tick();
        i2c_byte_vld = 1'b0;
        #1;
        chk("arb_reg5_i2c", cfg_regs[47:40], 8'h77);
        chk("arb_ack", host_ack, 1'b1);
        tick();
        chk("arb_reg5_host", cfg_regs[47:40], 8'h5A);
        chk("arb_noreack", host_ack, 1'b0);
        host_we = 1'b0;
        i2c_idle = 1'b1;
        tick(); tick();
        mbank[5] = 8'h5A;
        mbank[15] = mbank[15] + 8'd1;
        chk("arb_upd", upd_cnt - base, 1);
        check_bank("arb");

        // STOP arriving with a byte: the byte is dropped.
        base = upd_cnt;
        i2c_idle = 1'b0;
        tick(); tick();
        send_byte(8'h50); tick();
        send_byte(8'h02); tick();
        send_byte(8'h12); tick();
        i2c_byte = 8'h34; i2c_byte_vld = 1'b1; i2c_idle = 1'b1;
        tick();
        i2c_byte_vld = 1'b0;
        tick();
        mbank[2] = 8'h12;
        mbank[15] = mbank[15] + 8'd1;
        chk("drop_upd", upd_cnt - base, 1);
        check_bank("drop");

        // Reset in the middle of a write transaction.
        base = upd_cnt;
        i2c_idle = 1'b0;
        tick(); tick();
        send_byte(8'h50); tick();
        send_byte(8'h04); tick();
        rst = 1'b1;
        tick();
        chk("mrst_cfg", cfg_regs, 120'h0);
        chk("mrst_busy", busy, 1'b0);
        tick();
        chk("mrst_rdata", host_rdata, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
        tick();
        chk("mrst_upd", upd_cnt - base, 0);
        chk("mrst_restart", busy, 1'b1);
        txq = '{8'h50, 8'h01, 8'hC3};
        run_txn("after_rst");

        // Randomized mix of write transactions, read transactions and host writes.
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                host_write(4'($urandom_range(0, 15)), 8'($urandom), "rnd_hw");
            end else begin
                txq = {};
                txq.push_back({7'($urandom), (kind == 2) ? 1'b1 : 1'b0});
                txq.push_back(8'($urandom));
                len = $urandom_range(0, 6);
                for (int k = 0; k < len; k++) txq.push_back(8'($urandom));
                run_txn((kind == 2) ? "rnd_rd" : "rnd_wr");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_reg_ctrl.md
I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

Interface
REQ-001 SHALL have no parameters; the register bank is fixed at 16 x 8 bit (addresses 0..15).
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i2c_byte  input  8  byte from the I2C slave's received-data output; valid only with i2c_byte_vld.
REQ-005 i2c_byte_vld  input  1  one-cycle strobe: a byte has been received and ACKed by the I2C slave.
REQ-006 i2c_idle  input  1  high when no I2C transfer is in progress, i.e. between STOP and START.
REQ-007 host_we  input  1  local write request; held high until host_ack.
REQ-008 host_addr  input  4  local write address.
REQ-009 host_wdata  input  8  local write data.
REQ-010 host_ack  output  1  one-cycle pulse: host write accepted.
REQ-011 host_raddr  input  4  local read address.
REQ-012 host_rdata  output  8  contents of reg[host_raddr], registered, 1-cycle latency.
REQ-013 cfg_regs  output  120  registers 0..14 flattened; reg[n] sits at bits [8n+7:8n].
REQ-014 cfg_update  output  1  one-cycle pulse when an I2C write transaction ends having written at least one byte.
REQ-015 busy  output  1  high whenever the state is not S_IDLE.

Function
REQ-016 SHALL implement states S_IDLE, S_DEV, S_PTR, S_DATA, S_READ.
REQ-017 S_IDLE: when i2c_idle=0, go to S_DEV next cycle.
REQ-018 S_DEV on i2c_byte_vld (the device-address byte):
  - i2c_byte[0]=1 -> S_READ.
  - i2c_byte[0]=0 -> S_PTR.
REQ-019 S_PTR on i2c_byte_vld: ptr <= i2c_byte[3:0]; bits [7:4] are ignored; go to S_DATA.
REQ-020 S_DATA on i2c_byte_vld:
  - write reg[ptr] <= i2c_byte (except address 15, see REQ-022).
  - ptr <= ptr+1; wraps 15 -> 0.
  - set the wrote flag.
REQ-021 S_READ: ignore all i2c_byte_vld; remain until i2c_idle=1.
REQ-022 Register 15 is read-only, holding the transaction counter.
  - I2C writes to address 15 are discarded, but ptr still increments.
  - Host writes to address 15 are acked and discarded.
REQ-023 From any non-idle state, i2c_idle=1 -> S_IDLE next cycle.
  - This has priority over a simultaneous i2c_byte_vld; that byte is dropped.
REQ-024 On the S_DATA -> S_IDLE transition with wrote flag=1:
  - cfg_update pulses for 1 cycle.
  - reg[15] increments, wrapping 255 -> 0.
  - the wrote flag clears.
  - The wrote flag also clears on entry to S_DEV.
REQ-025 Bank write arbitration, one write port per cycle:
  - an I2C write (REQ-020) has priority.
  - a host write is accepted only in a cycle with no I2C write; it then writes reg[host_addr] and pulses host_ack that same cycle.
REQ-026 Host write latency: host_ack is asserted in the request cycle if there is no conflict, otherwise in the first cycle after.
  - host_ack SHALL not repeat while host_we stays high without a new request: after an ack, a new request requires host_we to deassert for at least 1 cycle.
REQ-027 host_rdata SHALL reflect bank contents as of the previous clock edge, with 1-cycle latency from host_raddr.
REQ-028 A repeated START without STOP is not supported.
  - i2c_idle stays low across it, so subsequent bytes are treated per the current state.
REQ-029 cfg_regs SHALL be driven directly from register flops, with no combinational path from inputs.

Reset
REQ-030 With rst=1 at a clock edge, all of the following take effect and hold while rst is high:
  - state=S_IDLE, ptr=0, wrote flag=0.
  - all 16 registers = 0x00.
  - host_ack=0, host_rdata=0x00, cfg_update=0, busy=0.
REQ-031 Reset mid-transaction SHALL abort it without a cfg_update pulse.
  - After reset release, the FSM waits in S_IDLE until i2c_idle=0 (that is, a transfer still in progress at release restarts at S_DEV).

Verification
REQ-032 Write transaction. Stimulus: i2c_idle 1->0; bytes 0x50, 0x03, 0xAA, 0xBB; then i2c_idle=1. Required response: reg3=0xAA, reg4=0xBB, cfg_update single pulse, reg15=0x01.
REQ-033 Pointer wrap. Stimulus: ptr byte 0x0E, data 0x11, 0x22, 0x33. Required response: reg14=0x11, reg15 unchanged by data (0x22 discarded), reg0=0x33; reg15 increments by 1 at STOP.
REQ-034 Read transaction. Stimulus: bytes 0x51, 0x07, 0x99; STOP. Required response: no register changes, no cfg_update, reg15 unchanged.
REQ-035 Arbitration. Stimulus: host_we, addr 5, data 0x5A, in the same cycle as I2C data byte 0x77 to ptr 5. Required response: reg5=0x77 first, then host_ack one cycle later, and final reg5=0x5A.
REQ-036 Reset and edge cases:
  - rst asserted after the ptr byte -> all registers 0, no cfg_update.
  - A transaction of only dev and ptr bytes then STOP -> no cfg_update, reg15 unchanged.
  - i2c_idle=1 coincident with i2c_byte_vld -> byte dropped.
